// File: rtl/add12u_share_pkg.sv
// rtl/add12u_share_pkg.sv - shared widths, constants and output-state enum for add12u_share_arb
package add12u_share_pkg;

    localparam int DW   = 12;
    localparam int SW   = 13;
    localparam int ERRW = 16;
    localparam logic [ERRW-1:0] ERR_SAT = 16'hFFFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/add12u_share_arb_if.sv
// rtl/add12u_share_arb_if.sv - request/result bundle between lanes and the shared adder arbiter
interface add12u_share_arb_if
    import add12u_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic [SW-1:0]      res_sum;
    logic [IDW-1:0]     res_id;
    logic [ERRW-1:0]    err_cnt;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id, err_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id, err_cnt
    );

endinterface

// File: rtl/add12u_lsbt_core.sv
// rtl/add12u_lsbt_core.sv - 12-bit approximate adder: bit 0 passes a[0], upper bits add exactly
module add12u_lsbt_core
    import add12u_share_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [SW-1:0] s
);

    // b[0] and the bit-0 carry are dropped; error is 1 exactly when b[0]=1
    assign s[0]    = a[0];
    assign s[SW-1:1] = {1'b0, a[DW-1:1]} + {1'b0, b[DW-1:1]};

endmodule

// File: rtl/add12u_share_arb.sv
// rtl/add12u_share_arb.sv - round-robin sharing of one approximate adder; optional ADD12U_SHARE_ARB_ERRCNT_EN
module add12u_share_arb
    import add12u_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input logic               clk,
    input logic               rst_n,
    add12u_share_arb_if.slave bus
);

    out_state_e     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] next_ptr;
    logic           any_valid;
    logic           slot_free;
    logic           accept;
    logic [DW-1:0]  a_g;
    logic [DW-1:0]  b_g;
    logic [SW-1:0]  sum_g;
    logic [SW-1:0]  sum_q;
    logic [IDW-1:0] id_q;

    // Walk from the farthest candidate back to rr_ptr so the last hit is the first in rotation
    always_comb begin
        int idx;
        grant     = rr_ptr;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                grant     = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign slot_free = (state == EMPTY) || bus.res_ready;
    assign accept    = rst_n && slot_free && any_valid;
    assign next_ptr  = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant] = 1'b1;
    end

    assign a_g = bus.req_a[int'(grant)*DW +: DW];
    assign b_g = bus.req_b[int'(grant)*DW +: DW];

    add12u_lsbt_core u_core (
        .a (a_g),
        .b (b_g),
        .s (sum_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            sum_q  <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            state  <= FULL;
            sum_q  <= sum_g;
            id_q   <= grant;
            rr_ptr <= next_ptr;
        end else if (bus.res_ready) begin
            state  <= EMPTY;
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_id    = id_q;

`ifdef ADD12U_SHARE_ARB_ERRCNT_EN
    logic [ERRW-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (accept && b_g[0] && (err_q != ERR_SAT)) begin
            err_q <= err_q + ERRW'(1);
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_add12u_share_arb.sv
// tb/tb_add12u_share_arb.sv - self-checking bench for add12u_share_arb against a behavioural model
module tb_add12u_share_arb;
    import add12u_share_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add12u_share_arb_if #(.NREQ(NREQ)) bus ();

    add12u_share_arb #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int op_a [NREQ];
    int op_b [NREQ];

    bit m_valid;
    int m_sum;
    int m_id;
    int m_rr;
    int m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // approximate result equals the true sum minus b's LSB
    function automatic int approx_sum(input int a, input int b);
        return a + b - (b & 1);
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        op_a[i] = a & 12'hFFF;
        op_b[i] = b & 12'hFFF;
        bus.req_a[i*DW +: DW] = DW'(op_a[i]);
        bus.req_b[i*DW +: DW] = DW'(op_b[i]);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = 0;
        m_id    = 0;
        m_rr    = 0;
        m_err   = 0;
    endtask

    // Entered one time unit after a rising edge; leaves at the same phase of the next cycle
    task automatic step(input logic [NREQ-1:0] v, input bit rdy);
        int g;
        bit acc;
        logic [NREQ-1:0] exp_rdy;
        bus.req_valid = v;
        bus.res_ready = rdy;
        #3;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        acc = (g >= 0) && (!m_valid || rdy);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_sum   = approx_sum(op_a[g], op_b[g]);
            m_id    = g;
            m_rr    = (g + 1) % NREQ;
`ifdef ADD12U_SHARE_ARB_ERRCNT_EN
            if ((op_b[g] & 1) == 1 && m_err < 65535) m_err++;
`endif
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        check("res_valid", 32'(bus.res_valid), 32'(m_valid));
        if (m_valid) begin
            check("res_sum", 32'(bus.res_sum), 32'(m_sum));
            check("res_id", 32'(bus.res_id), 32'(m_id));
        end
        check("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    endtask

    initial begin
        model_reset();
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0);

        // reset state, including req_ready gated low while valid is asserted
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_sum", 32'(bus.res_sum), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single lane, all-ones style operands
        set_op(2, 12'hFFF, 12'hFFE);
        step(4'b0100, 1'b1);
        check("single_sum", 32'(bus.res_sum), 32'h1FFD);
        check("single_id", 32'(bus.res_id), 32'd2);

        // inexact case: exact sum would be 1
        set_op(2, 12'h000, 12'h001);
        step(4'b0100, 1'b1);
        check("inexact_sum", 32'(bus.res_sum), 32'd0);
        step(4'b0000, 1'b1);

        // round robin with all lanes valid, no bubbles
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
            step(4'b1111, 1'b1);
        end

        // backpressure: hold for three cycles, then drain and accept together
        for (int c = 0; c < 3; c++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // move pointer to 3, then only lanes 1 and 3 compete
        set_op(2, 12'h123, 12'h456);
        step(4'b0100, 1'b1);
        set_op(1, 12'hABC, 12'h011);
        set_op(3, 12'h7FF, 12'h801);
        for (int c = 0; c < 3; c++) step(4'b1010, 1'b1);

        // randomized traffic with random backpressure
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
            step(4'($urandom), ($urandom % 4) != 0);
        end

        // async reset between edges with a result in flight
        step(4'b1111, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(bus.res_valid), 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd0);
        check("arst_res_sum", 32'(bus.res_sum), 32'd0);
        check("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
        model_reset();
        bus.req_valid = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus.res_valid), 32'd0);
        set_op(1, 12'h010, 12'h020);
        set_op(3, 12'h030, 12'h040);
        step(4'b1010, 1'b1);
        check("post_rst_grant", 32'(bus.res_id), 32'd1);
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
